// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cpu_pkg
// Description : Shared widths, default constants and fetch-stage types.
//               PC_W / INSTR_W : program counter and instruction widths
//               NOP_INSTR      : default bubble instruction
//               fetch_state_t  : fetch request state (IDLE / WAIT / DROP)
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 16;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  // IDLE : no request outstanding
  // WAIT : request outstanding, response will be buffered
  // DROP : request outstanding, response belongs to a squashed path
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/fetch_buf.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buf
// Description : Synchronous FIFO used as the fetch prefetch buffer.
//               clk, rst_n : clock, synchronous active-low reset
//               push, din  : write request and data
//               pop        : read request (head advances)
//               clear      : empty the buffer; wins over push and pop
//               full/empty : occupancy flags
//               count      : number of stored entries
//               head       : oldest entry (meaningful only when !empty)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2   // power of two, >= 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  input  logic                       clear,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           head
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + c_CNT_W'(w_do_push) - c_CNT_W'(w_do_pop);
    end
  end

  // Storage carries no reset; stale contents are never exposed while empty.
  always_ff @(posedge clk) begin
    if (w_do_push && !clear) r_mem[r_wr_ptr] <= din;
  end

  assign full  = (r_count == c_CNT_W'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign head  = r_mem[r_rd_ptr];

endmodule : fetch_buf
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit
// Description : Instruction fetch stage. Generates the PC, runs a single-
//               outstanding req/ack handshake to instruction memory, buffers
//               returned words and presents the head entry to IF/ID.
//               clk, rst_n                  : clock, synchronous active-low reset
//               imem_req/addr/ack/rdata     : instruction memory handshake
//               redirect_valid/redirect_pc  : taken branch/jump from EX
//               stall_if                    : IF/ID will not accept this cycle
//               if_pc/if_instr/if_valid     : head entry towards IF/ID
//               flush_id                    : clear IF/ID (same cycle as redirect)
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit #(
  parameter logic [cpu_pkg::PC_W-1:0]    RESET_PC  = 16'h0000,
  parameter int                          BUF_DEPTH = 2,
  parameter logic [cpu_pkg::INSTR_W-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic                          imem_req,
  output logic [cpu_pkg::PC_W-1:0]      imem_addr,
  input  logic                          imem_ack,
  input  logic [cpu_pkg::INSTR_W-1:0]   imem_rdata,
  input  logic                          redirect_valid,
  input  logic [cpu_pkg::PC_W-1:0]      redirect_pc,
  input  logic                          stall_if,
  output logic [cpu_pkg::PC_W-1:0]      if_pc,
  output logic [cpu_pkg::INSTR_W-1:0]   if_instr,
  output logic                          if_valid,
  output logic                          flush_id
);

  import cpu_pkg::*;

  localparam int                 c_CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int                 c_ENT_W = PC_W + INSTR_W;
  localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(BUF_DEPTH);

  fetch_state_t       r_state;
  fetch_state_t       w_state_nxt;
  logic [PC_W-1:0]    r_fetch_pc;
  logic [PC_W-1:0]    w_fetch_pc_nxt;
  logic [PC_W-1:0]    r_pending;
  logic [PC_W-1:0]    w_pending_nxt;

  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [c_CNT_W-1:0] w_count;
  logic [c_CNT_W-1:0] w_count_after;
  logic [c_ENT_W-1:0] w_din;
  logic [c_ENT_W-1:0] w_head;

  // A redirect squashes the ack in the same cycle, so nothing is pushed.
  assign w_push = (r_state == WAIT) && imem_ack && !redirect_valid;
  assign w_pop  = !w_empty && !stall_if;
  assign w_din  = {r_fetch_pc, imem_rdata};

  // Occupancy after this edge, ignoring a clear (the redirect path handles that).
  assign w_count_after = w_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);

  fetch_buf #(
    .WIDTH (c_ENT_W),
    .DEPTH (BUF_DEPTH)
  ) u_fetch_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .din   (w_din),
    .pop   (w_pop),
    .clear (redirect_valid),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count),
    .head  (w_head)
  );

  // State, fetch address and pending redirect target.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_pending  <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_pending  <= w_pending_nxt;
    end
  end

  // Next-state and address update.
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_pending_nxt  = r_pending;
    case (r_state)
      IDLE: begin
        if (redirect_valid) begin
          // Take the new target now; launch from it next cycle.
          w_fetch_pc_nxt = redirect_pc;
        end else if (!w_full) begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          if (imem_ack) begin
            w_fetch_pc_nxt = redirect_pc;
            w_state_nxt    = IDLE;
          end else begin
            // Request cannot be retracted; wait out its response.
            w_pending_nxt = redirect_pc;
            w_state_nxt   = DROP;
          end
        end else if (imem_ack) begin
          w_fetch_pc_nxt = r_fetch_pc + 1'b1;
          if (w_count_after >= c_DEPTH) w_state_nxt = IDLE;
        end
      end
      DROP: begin
        if (imem_ack) begin
          // Latest redirect wins, even one arriving with the ack.
          w_fetch_pc_nxt = redirect_valid ? redirect_pc : r_pending;
          w_state_nxt    = IDLE;
        end else if (redirect_valid) begin
          w_pending_nxt = redirect_pc;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    imem_req  = (r_state != IDLE);
    imem_addr = r_fetch_pc;
    if_valid  = !w_empty;
    if_pc     = w_empty ? '0 : w_head[c_ENT_W-1:INSTR_W];
    if_instr  = w_empty ? NOP_INSTR : w_head[INSTR_W-1:0];
    flush_id  = redirect_valid;
  end

endmodule : if_fetch_unit
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_unit
// Description : Self-checking bench for if_fetch_unit. A memory model answers
//               requests with rdata = addr ^ 16'hA5A5 after a configurable
//               latency. The expected delivery stream is a queue of PCs that
//               restarts at RESET_PC on reset and at the target on redirect;
//               a monitor pops and compares on every accepted head entry.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

  localparam logic [15:0] c_RST_PC = 16'hFFFE;
  localparam logic [15:0] c_NOP    = 16'h00F0;
  localparam logic [15:0] c_XOR    = 16'hA5A5;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        stall_if;
  logic [15:0] if_pc;
  logic [15:0] if_instr;
  logic        if_valid;
  logic        flush_id;

  int n_cmp;
  int n_fail;

  // memory model controls / status
  int lat_min;
  int lat_max;
  int lat_left;
  int wait_cyc;
  int force_ack_n;
  bit busy;

  // scoreboard
  logic [15:0] exp_q[$];
  logic [15:0] exp_next;

  if_fetch_unit #(
    .RESET_PC  (c_RST_PC),
    .BUF_DEPTH (2),
    .NOP_INSTR (c_NOP)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall_if       (stall_if),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_valid       (if_valid),
    .flush_id       (flush_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected stream: consecutive word addresses from a restart point.
  function automatic void sb_restart(input logic [15:0] pc);
    exp_q.delete();
    exp_next = pc;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(exp_next);
      exp_next = exp_next + 16'd1;
    end
  endfunction

  // Instruction memory model.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 16'h0000;
    busy       = 1'b0;
    wait_cyc   = 0;
    lat_left   = 0;
    forever begin
      @(posedge clk);
      #1;
      if (force_ack_n > 0) begin
        imem_ack    = 1'b1;
        imem_rdata  = 16'hDEAD;
        force_ack_n = force_ack_n - 1;
        busy        = 1'b0;
      end else if (!imem_req) begin
        imem_ack = 1'b0;
        busy     = 1'b0;
      end else begin
        if (!busy) begin
          busy     = 1'b1;
          wait_cyc = 0;
          lat_left = $urandom_range(lat_max, lat_min);
        end else begin
          wait_cyc = wait_cyc + 1;
        end
        if (lat_left == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = imem_addr ^ c_XOR;
          busy       = 1'b0;
        end else begin
          imem_ack = 1'b0;
          lat_left = lat_left - 1;
        end
      end
    end
  end

  // Monitor: samples mid-cycle, i.e. the values the next posedge will see.
  initial begin
    logic        p_rst;
    logic        p_req;
    logic        p_ack;
    logic [15:0] p_addr;
    logic [15:0] e;
    p_rst  = 1'b1;
    p_req  = 1'b0;
    p_ack  = 1'b0;
    p_addr = 16'h0000;
    forever begin
      @(negedge clk);
      check("flush_id", {31'd0, flush_id}, {31'd0, redirect_valid});
      if (!p_rst) begin
        check("rst_imem_req", {31'd0, imem_req}, 32'd0);
        check("rst_if_valid", {31'd0, if_valid}, 32'd0);
        check("rst_if_pc", {16'd0, if_pc}, 32'd0);
        check("rst_if_instr", {16'd0, if_instr}, {16'd0, c_NOP});
      end else if (p_req && !p_ack) begin
        check("req_held", {31'd0, imem_req}, 32'd1);
        check("addr_held", {16'd0, imem_addr}, {16'd0, p_addr});
      end
      if (!rst_n) begin
        sb_restart(c_RST_PC);
      end else if (redirect_valid) begin
        sb_restart(redirect_pc);
      end else if (if_valid && !stall_if) begin
        e = exp_q.pop_front();
        check("if_pc", {16'd0, if_pc}, {16'd0, e});
        check("if_instr", {16'd0, if_instr}, {16'd0, e ^ c_XOR});
        exp_q.push_back(exp_next);
        exp_next = exp_next + 16'd1;
      end
      p_rst  = rst_n;
      p_req  = imem_req;
      p_ack  = imem_ack;
      p_addr = imem_addr;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [15:0] frozen;
    logic [15:0] held;
    bit          found;
    int          r;
    n_cmp          = 0;
    n_fail         = 0;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    stall_if       = 1'b0;
    lat_min        = 0;
    lat_max        = 0;
    force_ack_n    = 0;

    // 1/5: reset, zero-wait memory, wrap from FFFE
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("lat_req_idle", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    check("lat_req_wait", {31'd0, imem_req}, 32'd1);
    check("lat_not_yet_valid", {31'd0, if_valid}, 32'd0);
    @(negedge clk);
    check("lat_valid", {31'd0, if_valid}, 32'd1);
    check("first_pc", {16'd0, if_pc}, {16'd0, c_RST_PC});
    repeat (12) begin
      @(negedge clk);
      check("stream_valid", {31'd0, if_valid}, 32'd1);
    end

    // 2: stall with full buffer
    tick();
    stall_if = 1'b1;
    frozen   = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) frozen = if_pc;
      else check("stall_pc_frozen", {16'd0, if_pc}, {16'd0, frozen});
      check("stall_valid", {31'd0, if_valid}, 32'd1);
      if (i >= 2) check("stall_no_req", {31'd0, imem_req}, 32'd0);
    end
    tick();
    stall_if = 1'b0;

    // 3: redirect in the 2nd cycle of a 3-cycle-latency request
    lat_min = 3;
    lat_max = 3;
    found   = 1'b0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (imem_req && busy && wait_cyc == 1) begin
        found = 1'b1;
        break;
      end
    end
    check("t3_wait_found", {31'd0, found}, 32'd1);
    held           = imem_addr;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0040;
    tick();
    redirect_valid = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (imem_ack) begin
        found = 1'b1;
        break;
      end
      check("t3_req_held", {31'd0, imem_req}, 32'd1);
      check("t3_addr_held", {16'd0, imem_addr}, {16'd0, held});
    end
    check("t3_drop_ack_seen", {31'd0, found}, 32'd1);
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (imem_req) begin
        found = 1'b1;
        break;
      end
    end
    check("t3_req_seen", {31'd0, found}, 32'd1);
    check("t3_next_addr", {16'd0, imem_addr}, 32'h0040);

    // 4: redirect coincident with ack
    lat_min = 2;
    lat_max = 2;
    found   = 1'b0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (imem_req && imem_ack) begin
        found = 1'b1;
        break;
      end
    end
    check("t4_ack_found", {31'd0, found}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h1234;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("t4_idle_after", {31'd0, imem_req}, 32'd0);
    check("t4_no_entry", {31'd0, if_valid}, 32'd0);
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (imem_req) begin
        found = 1'b1;
        break;
      end
    end
    check("t4_req_seen", {31'd0, found}, 32'd1);
    check("t4_next_addr", {16'd0, imem_addr}, 32'h1234);

    // 6: reset while a request is outstanding, late ack after release
    lat_min = 3;
    lat_max = 3;
    found   = 1'b0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (imem_req && busy && !imem_ack) begin
        found = 1'b1;
        break;
      end
    end
    check("t6_wait_found", {31'd0, found}, 32'd1);
    rst_n       = 1'b0;
    force_ack_n = 2;
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_late_ack_present", {31'd0, imem_ack}, 32'd1);
    @(negedge clk);
    check("t6_late_ack_ignored", {31'd0, if_valid}, 32'd0);
    check("t6_req", {31'd0, imem_req}, 32'd1);
    check("t6_first_addr", {16'd0, imem_addr}, {16'd0, c_RST_PC});

    // randomized traffic
    lat_min = 0;
    lat_max = 3;
    for (int c = 0; c < 3000; c++) begin
      tick();
      stall_if = ($urandom_range(0, 99) < 30);
      r        = $urandom_range(0, 299);
      if (r == 0) begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
      end else begin
        rst_n          = 1'b1;
        redirect_valid = (r < 15);
        if ($urandom_range(0, 3) == 0) redirect_pc = 16'hFFFC + 16'($urandom_range(0, 3));
        else redirect_pc = 16'($urandom);
      end
    end
    tick();
    rst_n          = 1'b1;
    redirect_valid = 1'b0;
    stall_if       = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_if_fetch_unit
`default_nettype wire
